// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if
//   ID-stage bundle between the pipeline front end and the hazard/forwarding
//   unit.
//   master: drives the ID instruction fields and flush, observes the results.
//   slave : the hazard/forwarding unit.
//   Signals:
//     id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
//     id_wreg, id_m2reg, id_rd, flush              (master -> slave)
//     fwda, fwdb, stall, ex_wreg, mem_wreg         (slave -> master)
interface hazard_fwd_unit_if;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_use_rs;
    logic       id_use_rt;
    logic       id_wreg;
    logic       id_m2reg;
    logic [4:0] id_rd;
    logic       flush;
    logic [1:0] fwda;
    logic [1:0] fwdb;
    logic       stall;
    logic       ex_wreg;
    logic       mem_wreg;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_rd, flush,
        input  fwda, fwdb, stall, ex_wreg, mem_wreg
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_wreg, id_m2reg, id_rd, flush,
        output fwda, fwdb, stall, ex_wreg, mem_wreg
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard detection and operand forwarding for the five-stage pipeline.
//   Keeps a shadow of the destination info of the instructions in EX and MEM
//   and produces the operand mux selects and the load-use stall.
//   Ports:
//     clk  - pipeline clock, rising edge
//     rst  - asynchronous, active-high reset (clears both shadow slots)
//     bus  - hazard_fwd_unit_if.slave (ID inputs in, fwda/fwdb/stall and
//            slot write-enables out)
//   Select encoding: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data.
//   Build option: HAZARD_FWD_EN
//     defined   - full forwarding, stall only on load-use in EX
//     undefined - selects tied to 00, stall on any RAW against EX or MEM
module hazard_fwd_unit (
    input  logic             clk,
    input  logic             rst,
    hazard_fwd_unit_if.slave bus
);
    logic       r_ex_wreg;
    logic [4:0] r_ex_rd;
    logic       r_mem_wreg;
    logic [4:0] r_mem_rd;
`ifdef HAZARD_FWD_EN
    logic       r_ex_m2reg;
    logic       r_mem_m2reg;
`endif

    logic       w_rs_live;
    logic       w_rt_live;
    logic       w_ex_hit_rs;
    logic       w_ex_hit_rt;
    logic       w_mem_hit_rs;
    logic       w_mem_hit_rt;
    logic       w_haz_rs;
    logic       w_haz_rt;
    logic       w_stall;
    logic       w_ex_load;
    logic [1:0] w_fwda;
    logic [1:0] w_fwdb;

    // A source only matters when it is really read, is not r0, and ID is real.
    assign w_rs_live    = bus.id_valid && bus.id_use_rs && (bus.id_rs != 5'd0);
    assign w_rt_live    = bus.id_valid && bus.id_use_rt && (bus.id_rt != 5'd0);
    assign w_ex_hit_rs  = w_rs_live && r_ex_wreg  && (r_ex_rd  == bus.id_rs);
    assign w_ex_hit_rt  = w_rt_live && r_ex_wreg  && (r_ex_rd  == bus.id_rt);
    assign w_mem_hit_rs = w_rs_live && r_mem_wreg && (r_mem_rd == bus.id_rs);
    assign w_mem_hit_rt = w_rt_live && r_mem_wreg && (r_mem_rd == bus.id_rt);

`ifdef HAZARD_FWD_EN
    // EX hit wins over MEM hit; a load in EX cannot be forwarded yet.
    function automatic logic [1:0] fwd_sel(
        input logic i_ex_hit,
        input logic i_ex_m2reg,
        input logic i_mem_hit,
        input logic i_mem_m2reg
    );
        if (i_ex_hit)
            return i_ex_m2reg ? 2'b00 : 2'b01;
        else if (i_mem_hit)
            return i_mem_m2reg ? 2'b11 : 2'b10;
        else
            return 2'b00;
    endfunction

    assign w_haz_rs = w_ex_hit_rs && r_ex_m2reg;
    assign w_haz_rt = w_ex_hit_rt && r_ex_m2reg;
    assign w_fwda   = fwd_sel(w_ex_hit_rs, r_ex_m2reg, w_mem_hit_rs, r_mem_m2reg);
    assign w_fwdb   = fwd_sel(w_ex_hit_rt, r_ex_m2reg, w_mem_hit_rt, r_mem_m2reg);
`else
    // Without forwarding every RAW against an in-flight writer must wait.
    assign w_haz_rs = w_ex_hit_rs || w_mem_hit_rs;
    assign w_haz_rt = w_ex_hit_rt || w_mem_hit_rt;
    assign w_fwda   = 2'b00;
    assign w_fwdb   = 2'b00;
`endif

    // Flush discards the ID instruction, so its hazard is moot.
    assign w_stall   = (w_haz_rs || w_haz_rt) && !bus.flush;
    assign w_ex_load = bus.id_valid && !w_stall && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_wreg  <= 1'b0;
            r_ex_rd    <= 5'd0;
            r_mem_wreg <= 1'b0;
            r_mem_rd   <= 5'd0;
        end else begin
            // MEM always drains from EX, even while ID is stalled.
            r_mem_wreg <= r_ex_wreg;
            r_mem_rd   <= r_ex_rd;
            r_ex_wreg  <= w_ex_load ? bus.id_wreg : 1'b0;
            r_ex_rd    <= w_ex_load ? bus.id_rd   : 5'd0;
        end
    end

`ifdef HAZARD_FWD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_m2reg  <= 1'b0;
            r_mem_m2reg <= 1'b0;
        end else begin
            r_mem_m2reg <= r_ex_m2reg;
            r_ex_m2reg  <= w_ex_load ? bus.id_m2reg : 1'b0;
        end
    end
`endif

    assign bus.fwda     = w_fwda;
    assign bus.fwdb     = w_fwdb;
    assign bus.stall    = w_stall;
    assign bus.ex_wreg  = r_ex_wreg;
    assign bus.mem_wreg = r_mem_wreg;
endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Hazard and forwarding control for the five-stage pipeline, sitting in ID directly upstream of the operand `mux4x32` pair that feeds the ID/EX register. It keeps a two-slot shadow of the destination info of the instructions in EX and MEM and, each cycle, produces the 2-bit operand selects `fwda`/`fwdb`. It also produces the `stall` that freezes PC and IF/ID and inserts a bubble into EX on load-use (or, without forwarding, any RAW) hazards.

## Interface
- No parameters (register address width fixed at 5, selects fixed at 2 bits).
- `clk  in  1` — pipeline clock, rising edge.
- `rst  in  1` — asynchronous, active-high reset.
- `id_valid  in  1` — ID holds a real instruction.
- `id_rs, id_rt  in  5` — source register numbers of the ID instruction.
- `id_use_rs, id_use_rt  in  1` — instruction actually reads rs / rt.
- `id_wreg  in  1` — ID instruction writes the register file.
- `id_m2reg  in  1` — ID instruction is a load (result from memory).
- `id_rd  in  5` — destination register number of the ID instruction.
- `flush  in  1` — taken branch/jump: instruction in ID is discarded.
- `fwda, fwdb  out  2` — select for rs/rt operand `mux4x32`.
- `stall  out  1` — hold PC and IF/ID, bubble EX.
- `ex_wreg, mem_wreg  out  1` — shadow slot write-enables (debug/observability).

## Operation
- Internal slots: EX = {wreg, m2reg, rd}, MEM = {wreg, m2reg, rd}.
- Select encoding (matches `mux4x32` inputs a0..a3): 00 register file, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- Per operand X∈{rs,rt}, with use_X=1, X≠0, and id_valid=1:
  - EX.wreg && EX.rd==X && !EX.m2reg → 01.
  - EX.wreg && EX.rd==X && EX.m2reg → load-use hazard, select 00.
  - Else MEM.wreg && MEM.rd==X → 10 if !MEM.m2reg, 11 if MEM.m2reg.
  - Else → 00.
- EX match has priority over MEM match.
- Register 0 is never forwarded and never causes a hazard.
- WB needs no handling: the register file writes on the falling edge.
- `stall` = (hazard on rs || hazard on rt) && !flush.
- Slot update at rising `clk`:
  - MEM ← EX unconditionally.
  - EX ← {id_wreg, id_m2reg, id_rd} if id_valid && !stall && !flush.
  - Otherwise EX ← bubble {0, 0, 0}.

## Timing
- Selects and `stall` are combinational from ID inputs and slot state: zero-cycle latency, valid in the same cycle.
- A load-use stall lasts exactly one cycle. The next cycle the load is in MEM and the select resolves to 11.
- Reset (asynchronous, any time, including mid-stall) clears both slots to {0, 0, 0}.
  - During and immediately after reset: `ex_wreg`=0, `mem_wreg`=0, `fwda`=`fwdb`=00, `stall`=0.
- flush and hazard in the same cycle: flush wins. `stall`=0 and EX receives a bubble.
- id_valid=0: no hazard, selects 00, EX receives a bubble.
- rs==rt: both selects are computed identically.
- MEM slot drains regardless of stall, so no hazard can persist more than the stated cycles.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as described above.
- `HAZARD_FWD_EN` undefined: `fwda`/`fwdb` are tied to 00.
  - `stall` asserts whenever a used, nonzero source matches a writing EX or MEM slot, load or not.
  - flush priority and slot update rules are unchanged.
  - A RAW on the EX slot stalls 2 cycles; a RAW on the MEM slot stalls 1 cycle.

## Test plan
- Reset: assert `rst` mid-stall after a load to r8 → `stall`=0, `fwda`=`fwdb`=00, `ex_wreg`=`mem_wreg`=0 immediately, without waiting for a clock.
- ALU chain: add r3 then sub r4,r3,r3 → in the sub's ID cycle `fwda`=`fwdb`=01. One instruction later, a reader of r3 → 10.
- Load-use: lw r5 then add r6,r5,r1 → `stall`=1 for one cycle with `fwda`=00, EX bubble; next cycle `fwda`=11, `stall`=0.
- Priority and r0: writers of r7 in both EX and MEM, reader of r7 → 01. Writer of r0 followed by a reader of r0 → 00, `stall`=0.
- Flush vs hazard: lw r5 in EX, ID reads r5, `flush`=1 → `stall`=0, next `ex_wreg`=0.
- `HAZARD_FWD_EN` undefined: add r3 followed by a reader of r3 → `stall`=1 for 2 cycles, selects always 00.
